// File: rtl/loader_pkg.sv
// Shared loader types: FSM state encoding, 32-bit word type and default address width.
// The CHECK state is only present when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int ADDR_W_DEF = 14;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/loader_if.sv
// Byte-stream input and SRAM write port of the program loader.
// The slave modport is the loader side; the master modport is the surrounding system.
interface loader_if #(
    parameter int ADDR_W = loader_pkg::ADDR_W_DEF
);
    import loader_pkg::*;

    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_ceb;
    logic              mem_web;
    logic [ADDR_W-1:0] mem_a;
    word_t             mem_d;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_ceb,
        output mem_web,
        output mem_a,
        output mem_d
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_ceb,
        input  mem_web,
        input  mem_a,
        input  mem_d
    );

endinterface

// File: rtl/loader_pack.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// wordDone_o pulses in the cycle the fourth byte is accepted; word_o already contains it then.
module loader_pack
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       byteValid_i,
    input  logic [7:0] byteData_i,
    output word_t      word_o,
    output logic       wordDone_o
);

    logic [1:0] byteIdx_q;
    word_t      lanes_q;
    word_t      lanes_d;

    always_comb begin
        lanes_d = lanes_q;
        if (byteValid_i) begin
            lanes_d[{byteIdx_q, 3'b000} +: 8] = byteData_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteIdx_q <= 2'd0;
            lanes_q   <= '0;
        end else begin
            lanes_q <= lanes_d;
            if (clear_i) begin
                byteIdx_q <= 2'd0;
            end else if (byteValid_i) begin
                byteIdx_q <= byteIdx_q + 2'd1;
            end
        end
    end

    assign word_o     = lanes_d;
    assign wordDone_o = byteValid_i && (byteIdx_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams bytes into 32-bit SRAM words, one word per five cycles, holding the CPU in reset until done.
// Define LOADER_CHECKSUM_EN to add a trailing 32-bit checksum word compared against the sum of written words.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    loader_if.slave           bus,
    output logic              busy,
    output logic              done,
    output logic              cpu_rst,
    output logic              err
);

    state_e            state_q;
    logic              sReady_q;
    logic              memCeb_q;
    logic              memWeb_q;
    logic [ADDR_W-1:0] memA_q;
    word_t             memD_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic              busy_q;
    logic              done_q;
    logic              cpuRst_q;

    logic              startAccept;
    logic              byteFire;
    word_t             packWord;
    logic              wordDone;

`ifdef LOADER_CHECKSUM_EN
    word_t             sum_q;
    logic              err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign startAccept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign byteFire    = bus.s_valid && sReady_q;

    loader_pack u_pack (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (startAccept),
        .byteValid_i (byteFire),
        .byteData_i  (bus.s_data),
        .word_o      (packWord),
        .wordDone_o  (wordDone)
    );

    // All outputs are registered and change only on state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sReady_q <= 1'b0;
            memCeb_q <= 1'b1;
            memWeb_q <= 1'b1;
            memA_q   <= '0;
            memD_q   <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cpuRst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (startAccept) begin
                        state_q  <= ST_RECV;
                        sReady_q <= (word_cnt != '0);
                        addr_q   <= base_addr;
                        remain_q <= word_cnt;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        cpuRst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q    <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                ST_RECV: begin
                    if (remain_q == '0) begin
                        state_q  <= ST_DONE;
                        sReady_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        cpuRst_q <= 1'b0;
                    end else if (wordDone) begin
                        state_q  <= ST_WRITE;
                        sReady_q <= 1'b0;
                        memCeb_q <= 1'b0;
                        memWeb_q <= 1'b0;
                        memA_q   <= addr_q;
                        memD_q   <= packWord;
                    end
                end
                ST_WRITE: begin
                    memCeb_q <= 1'b1;
                    memWeb_q <= 1'b1;
                    addr_q   <= addr_q + ADDR_W'(1);
                    remain_q <= remain_q - (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_q    <= sum_q + memD_q;
`endif
                    if (remain_q == (ADDR_W+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q  <= ST_CHECK;
                        sReady_q <= 1'b1;
`else
                        state_q  <= ST_DONE;
                        sReady_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        cpuRst_q <= 1'b0;
`endif
                    end else begin
                        state_q  <= ST_RECV;
                        sReady_q <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (wordDone) begin
                        err_q    <= (sum_q != packWord);
                        state_q  <= ST_DONE;
                        sReady_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        cpuRst_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q  <= ST_IDLE;
                    sReady_q <= 1'b0;
                    memCeb_q <= 1'b1;
                    memWeb_q <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    cpuRst_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.s_ready = sReady_q;
    assign bus.mem_ceb = memCeb_q;
    assign bus.mem_web = memWeb_q;
    assign bus.mem_a   = memA_q;
    assign bus.mem_d   = memD_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cpu_rst     = cpuRst_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of load jobs plus hand-written reset, wrap and checksum sequences.
// SRAM writes are checked against a scoreboard queue filled as words are streamed in.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int AW = 14;
`ifdef LOADER_CHECKSUM_EN
    localparam int TRAILER_CYC = 4;
`else
    localparam int TRAILER_CYC = 0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        word_t         data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   cnt;
        int            gapMax;
        bit            midStart;
        int            trailerOfs;
        bit            expErr;
        int            expCycles;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_cnt;
    logic          busy;
    logic          done;
    logic          cpu_rst;
    logic          err;

    int     checks = 0;
    int     failures = 0;
    int     cycleCnt = 0;
    int     doneCycle = -1;
    int     acceptCycle = 0;
    int     writesSeen = 0;
    logic   prevDone = 1'b0;
    wr_t    expQ[$];
    wr_t    monExp;
    word_t  srcWords[$];
    vec_t   vecs[$];
    logic [7:0] req34Bytes[8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    loader_if #(.ADDR_W(AW)) bus ();

    prog_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .cpu_rst   (cpu_rst),
        .err       (err)
    );

    // 100 MHz clock and a posedge counter used for throughput measurement
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every cycle with mem_ceb low is popped against the scoreboard
    always @(negedge clk) begin
        if (done && !prevDone) doneCycle = cycleCnt;
        prevDone = done;
        if (!bus.mem_ceb) begin
            writesSeen++;
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write", bus.mem_a, bus.mem_d);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("wr_web", {63'd0, bus.mem_web}, 64'd0);
                checkOutput("wr_addr", {50'd0, bus.mem_a}, {50'd0, monExp.addr});
                checkOutput("wr_data", {32'd0, bus.mem_d}, {32'd0, monExp.data});
            end
        end
    end

    // Presents one byte after 'gap' idle cycles and returns once it has transferred
    task automatic pushByte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            bus.s_valid = 1'b0;
            @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        t = 0;
        while (!bus.s_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) begin
            checks++;
            failures++;
            $display("[TB] FAIL byte_accept: s_ready stayed 0 for byte 0x%0h, want 1 within 60 cycles", b);
        end else begin
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic waitDone();
        int t;
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        #1;
        checkOutput("done", {63'd0, done}, 64'd1);
    endtask

    task automatic pulseStart(input logic [AW-1:0] b, input logic [AW:0] n);
        base_addr   = b;
        word_cnt    = n;
        start       = 1'b1;
        acceptCycle = cycleCnt + 1;
        doneCycle   = -1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one complete load job and checks the end state
    task automatic applyStimulus(input vec_t v);
        int            w0;
        logic [AW-1:0] a;
        word_t         sum;
        word_t         w;
        int            gap;
        w0  = writesSeen;
        a   = v.base;
        sum = '0;
        pulseStart(v.base, v.cnt);
        checkOutput("start_busy", {63'd0, busy}, 64'd1);
        checkOutput("start_done", {63'd0, done}, 64'd0);
        checkOutput("start_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        for (int i = 0; i < int'(v.cnt); i++) begin
            w = (srcWords.size() > 0) ? srcWords.pop_front() : word_t'($urandom);
            expQ.push_back('{a, w});
            a   = a + AW'(1);
            sum = sum + w;
            if (v.midStart && (i == int'(v.cnt) / 2)) begin
                base_addr = ~v.base;
                word_cnt  = 1;
                start     = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checkOutput("midstart_busy", {63'd0, busy}, 64'd1);
            end
            for (int k = 0; k < 4; k++) begin
                gap = (v.gapMax > 0) ? int'($urandom_range(0, v.gapMax)) : 0;
                pushByte(w[8*k +: 8], gap);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (v.cnt != '0) begin
            w = sum + word_t'(v.trailerOfs);
            for (int k = 0; k < 4; k++) pushByte(w[8*k +: 8], 0);
        end
`endif
        waitDone();
        checkOutput("end_cpu_rst", {63'd0, cpu_rst}, 64'd0);
        checkOutput("end_busy", {63'd0, busy}, 64'd0);
        checkOutput("end_err", {63'd0, err}, {63'd0, v.expErr});
        checkOutput("end_s_ready", {63'd0, bus.s_ready}, 64'd0);
        checkOutput("write_count", 64'(writesSeen - w0), 64'(int'(v.cnt)));
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        if (v.expCycles >= 0) begin
            checkOutput("cycles_start_to_done", 64'(doneCycle - acceptCycle), 64'(v.expCycles));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at 500 us, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0;
        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        word_cnt    = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #1 rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_s_ready", {63'd0, bus.s_ready}, 64'd0);
        checkOutput("rst_mem_ceb", {63'd0, bus.mem_ceb}, 64'd1);
        checkOutput("rst_mem_web", {63'd0, bus.mem_web}, 64'd1);
        checkOutput("rst_mem_a", {50'd0, bus.mem_a}, 64'd0);
        checkOutput("rst_mem_d", {32'd0, bus.mem_d}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_err", {63'd0, err}, 64'd0);
        checkOutput("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", {63'd0, busy}, 64'd0);

        $display("[TB] little-endian assembly at 0x2000");
        pulseStart(14'h2000, 15'd2);
        expQ.push_back('{14'h2000, 32'h12345678});
        expQ.push_back('{14'h2001, 32'hDEADBEEF});
        for (int i = 0; i < 8; i++) pushByte(req34Bytes[i], 0);
`ifdef LOADER_CHECKSUM_EN
        pushByte(8'h67, 0);
        pushByte(8'h15, 0);
        pushByte(8'hE2, 0);
        pushByte(8'hF0, 0);
`endif
        waitDone();
        checkOutput("req34_cpu_rst", {63'd0, cpu_rst}, 64'd0);
        checkOutput("req34_scoreboard", 64'(expQ.size()), 64'd0);
        checkOutput("req34_mem_ceb_idle", {63'd0, bus.mem_ceb}, 64'd1);
        checkOutput("req34_mem_a_hold", {50'd0, bus.mem_a}, 64'h2001);
        checkOutput("req34_mem_d_hold", {32'd0, bus.mem_d}, 64'hDEADBEEF);
        checkOutput("req34_err", {63'd0, err}, 64'd0);

        $display("[TB] reset in the middle of a load");
        w0 = writesSeen;
        @(negedge clk);
        pulseStart(14'h0040, 15'd4);
        expQ.push_back('{14'h0040, 32'hA1B2C3D4});
        pushByte(8'hD4, 0);
        pushByte(8'hC3, 0);
        pushByte(8'hB2, 0);
        pushByte(8'hA1, 0);
        pushByte(8'h11, 0);
        pushByte(8'h22, 0);
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        checkOutput("abort_s_ready", {63'd0, bus.s_ready}, 64'd0);
        checkOutput("abort_mem_ceb", {63'd0, bus.mem_ceb}, 64'd1);
        checkOutput("abort_mem_a", {50'd0, bus.mem_a}, 64'd0);
        checkOutput("abort_mem_d", {32'd0, bus.mem_d}, 64'd0);
        repeat (2) @(negedge clk);
        checkOutput("abort_write_count", 64'(writesSeen - w0), 64'd1);
        checkOutput("abort_scoreboard", 64'(expQ.size()), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_idle_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_idle_done", {63'd0, done}, 64'd0);

        // base, cnt, gapMax, midStart, trailerOfs, expErr, expCycles
        vecs.push_back('{14'h0100, 15'd3,  0, 1'b0, 0, 1'b0, 15 + TRAILER_CYC});
        vecs.push_back('{14'h3FFF, 15'd2,  0, 1'b0, 0, 1'b0, 10 + TRAILER_CYC});
        vecs.push_back('{14'h1234, 15'd0,  0, 1'b0, 0, 1'b0, 1});
        vecs.push_back('{14'h0800, 15'd16, 3, 1'b1, 0, 1'b0, -1});
        vecs.push_back('{14'h3FFE, 15'd1,  2, 1'b0, 0, 1'b0, -1});
        vecs.push_back('{14'h0000, 15'd5,  0, 1'b1, 0, 1'b0, -1});
        foreach (vecs[i]) begin
            $display("[TB] table job %0d: base 0x%0h count %0d", i, vecs[i].base, vecs[i].cnt);
            applyStimulus(vecs[i]);
        end

`ifdef LOADER_CHECKSUM_EN
        $display("[TB] checksum trailer match and mismatch");
        srcWords.push_back(32'd1);
        srcWords.push_back(32'd2);
        applyStimulus('{14'h0010, 15'd2, 0, 1'b0, 0, 1'b0, 10 + TRAILER_CYC});
        srcWords.push_back(32'd1);
        srcWords.push_back(32'd2);
        applyStimulus('{14'h0010, 15'd2, 0, 1'b0, 1, 1'b1, 10 + TRAILER_CYC});
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning memory word-address width (16384 words).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-005 SHALL have port base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-006 SHALL have port word_cnt  input  ADDR_W+1  words to load (0..2^ADDR_W), sampled on accepted start.
REQ-007 SHALL have port s_valid  input  1  byte-stream valid.
REQ-008 SHALL have port s_data  input  8  byte-stream data.
REQ-009 SHALL have port s_ready  output  1  byte-stream ready; a byte transfers when s_valid&&s_ready.
REQ-010 SHALL have port mem_ceb  output  1  SRAM chip enable, active-low.
REQ-011 SHALL have port mem_web  output  1  SRAM write enable, active-low.
REQ-012 SHALL have port mem_a  output  ADDR_W  SRAM word address.
REQ-013 SHALL have port mem_d  output  32  SRAM write data.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  load complete; held until next accepted start.
REQ-016 SHALL have port cpu_rst  output  1  active-high CPU reset; held during and before load.
REQ-017 SHALL have port err  output  1  checksum mismatch flag.

Function
REQ-018 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE; CHECK exists only with the macro of REQ-030.
REQ-019 IDLE/DONE: start accepted -> RECV, done=0, byte index=0, address=base_addr, remaining=word_cnt; if word_cnt==0 -> DONE next cycle with no SRAM write.
REQ-020 start while busy SHALL be ignored.
REQ-021 RECV: s_ready=1; byte k (k=0..3) of a word SHALL land in mem_d bits [8k+7:8k] (little-endian, byte0 LSB).
REQ-022 After the 4th byte SHALL go to WRITE for exactly one cycle: mem_ceb=0, mem_web=0, s_ready=0, mem_a=current address.
REQ-023 WRITE exit: address+1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0); remaining-1; remaining==0 -> CHECK (macro) or DONE, else RECV.
REQ-024 Throughput: one word per 5 cycles with s_valid held high; s_valid gaps SHALL stall without data loss.
REQ-025 Outside WRITE: mem_ceb=1, mem_web=1; mem_a/mem_d hold their last values.
REQ-026 busy=1 in RECV, WRITE, CHECK; cpu_rst=1 in all states except DONE; done=1 only in DONE.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, s_ready=0, mem_ceb=1, mem_web=1, mem_a=0, mem_d=0, busy=0, done=0, err=0, cpu_rst=1.
REQ-028 rst low mid-load SHALL abort immediately; a partially assembled word SHALL NOT be written.
REQ-029 Deassertion SHALL take effect on the next rising edge; no transfer in that edge's cycle is lost or duplicated.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined: running 32-bit sum (mod 2^32) of all written words; after last WRITE, CHECK receives 4 trailer bytes (little-endian), err=(sum!=trailer), then DONE; err cleared on accepted start.
REQ-031 Without LOADER_CHECKSUM_EN: no CHECK state, no trailer consumed, err constant 0.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum, ADDR_W default and the 32-bit word type.
REQ-033 Sub-module loader_pack SHALL perform byte-to-word assembly (byte index counter, word-complete pulse).

Verification
REQ-034 base_addr=0x2000, word_cnt=2, bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678@0x2000, 0xDEADBEEF@0x2001; done=1, cpu_rst=0.
REQ-035 base_addr=0x3FFF, word_cnt=2 -> writes at 0x3FFF then 0x0000.
REQ-036 word_cnt=0 -> no mem_ceb low; done=1 two cycles after start.
REQ-037 rst low after 6 bytes of word_cnt=4 load -> exactly one write seen; IDLE, cpu_rst=1; new load then completes normally.
REQ-038 Random s_valid gaps, word_cnt=16 -> SRAM contents match source; start pulse mid-load ignored.
REQ-039 LOADER_CHECKSUM_EN, words 1,2, trailer 3 -> err=0; trailer 4 -> err=1; both end in DONE.
